// File: rtl/display_pkg.sv
// Shared types and helpers for the BCD display front-end.
package display_pkg;

  // Digit code that the downstream 7-segment decoder renders as all segments off.
  localparam logic [3:0] BCD_BLANK = 4'hF;

  // Conversion engine states.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } disp_state_t;

  // Largest value representable in ndig decimal digits: 10^ndig - 1.
  function automatic int unsigned max_value(input int ndig);
    int unsigned p;
    p = 1;
    for (int i = 0; i < ndig; i++) begin
      p = p * 10;
    end
    return p - 1;
  endfunction

endpackage

// File: rtl/bcd_display_scan_if.sv
// Load/busy handshake plus the multiplexed digit bus of the display front-end.
interface bcd_display_scan_if #(
  parameter int NDIG  = 4,
  parameter int WIDTH = 14
);
  logic [WIDTH-1:0] value_in;
  logic             load;
  logic             busy;
  logic             ovf;
  logic [3:0]       bcd;
  logic [NDIG-1:0]  an;

  // Producer of values / consumer of the display bus.
  modport master (
    output value_in,
    output load,
    input  busy,
    input  ovf,
    input  bcd,
    input  an
  );

  // The display front-end itself.
  modport slave (
    input  value_in,
    input  load,
    output busy,
    output ovf,
    output bcd,
    output an
  );
endinterface

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: one binary bit per cycle, MSB first.
// done is high during the final iteration; result then carries the BCD
// digits that the shift register will hold after that edge, so the caller
// can commit on the same edge the engine returns to IDLE.
module bin2bcd_serial
  import display_pkg::*;
#(
  parameter int WIDTH = 14,
  parameter int NDIG  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  din,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] result
);

  localparam int SRW = WIDTH + 4 * NDIG;
  localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  disp_state_t    state;
  logic [SRW-1:0] sr;
  logic [SRW-1:0] sr_next;
  logic [CW-1:0]  cnt;

  // One double-dabble iteration: correct every BCD nibble >= 5, then shift left.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can leave it unassigned and infer a latch.
    sr_next = sr;
    for (int d = 0; d < NDIG; d++) begin
      if (sr[WIDTH + 4*d +: 4] >= 4'd5) begin
        sr_next[WIDTH + 4*d +: 4] = sr[WIDTH + 4*d +: 4] + 4'd3;
      end
    end
    sr_next = {sr_next[SRW-2:0], 1'b0};
  end

  // Engine FSM: capture on start, then WIDTH iterations counted WIDTH-1 down to 0.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sr    <= {{(4*NDIG){1'b0}}, din};
            cnt   <= CW'(WIDTH - 1);
            state <= CONV;
          end
        end
        CONV: begin
          sr <= sr_next;
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy   = (state == CONV);
  assign done   = (state == CONV) && (cnt == '0);
  assign result = sr_next[SRW-1 -: 4*NDIG];

endmodule

// File: rtl/bcd_display_scan.sv
// Multiplexed 4-digit display front-end: binary load handshake, serial BCD
// conversion, atomic display register, leading-zero/overflow blanking and
// digit scan onto a single BCD bus with active-low anode selects.
module bcd_display_scan
  import display_pkg::*;
#(
  parameter int NDIG        = 4,
  parameter int WIDTH       = 14,
  parameter int REFRESH_DIV = 50000,
  parameter int LZ_BLANK    = 1
) (
  input logic                clk,
  input logic                rst,
  bcd_display_scan_if.slave  bus
);

  localparam int          RW      = $clog2(REFRESH_DIV);
  localparam int          IW      = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned MAX_VAL = max_value(NDIG);

  logic              start;
  logic              eng_busy;
  logic              eng_done;
  logic [4*NDIG-1:0] eng_result;
  logic              ovf_cap;
  logic              ovf_q;
  logic [4*NDIG-1:0] disp;
  logic [RW-1:0]     refresh_cnt;
  logic [IW-1:0]     idx;
  logic [NDIG-1:0]   blank;
  logic              lz_seen;
  logic [3:0]        bcd_sel;

  // A load is taken only while the engine is idle; loads during busy are dropped.
  assign start = bus.load && !eng_busy;

  bin2bcd_serial #(
    .WIDTH (WIDTH),
    .NDIG  (NDIG)
  ) u_engine (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .din    (bus.value_in),
    .busy   (eng_busy),
    .done   (eng_done),
    .result (eng_result)
  );

  // Range check at capture time; the verdict travels with the conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cap <= 1'b0;
    end else if (start) begin
      ovf_cap <= (32'(bus.value_in) > MAX_VAL);
    end
  end

  // Commit on the final conversion cycle: all digits and ovf change together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp  <= '0;
      ovf_q <= 1'b0;
    end else if (eng_done) begin
      ovf_q <= ovf_cap;
      if (!ovf_cap) begin
        disp <= eng_result;
      end
    end
  end

  // Refresh divider and digit index; runs regardless of conversion activity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
      idx         <= '0;
    end else if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      idx         <= (idx == IW'(NDIG - 1)) ? '0 : idx + IW'(1);
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  // Blank mask: everything on overflow, otherwise zeros above the top non-zero digit.
  always_comb begin
    blank   = '0;
    lz_seen = 1'b0;
    for (int i = NDIG - 1; i >= 1; i--) begin
      lz_seen = lz_seen | (disp[4*i +: 4] != 4'd0);
      if ((LZ_BLANK != 0) && !lz_seen) begin
        blank[i] = 1'b1;
      end
    end
    if (ovf_q) begin
      blank = '1;
    end
  end

  // Digit select for the current scan position, from registered state only.
  always_comb begin
    bcd_sel = BCD_BLANK;
    for (int i = 0; i < NDIG; i++) begin
      if (idx == IW'(i)) begin
        bcd_sel = blank[i] ? BCD_BLANK : disp[4*i +: 4];
      end
    end
  end

  assign bus.bcd  = bcd_sel;
  assign bus.an   = ~(NDIG'(1) << idx);
  assign bus.busy = eng_busy;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed self-checking bench for bcd_display_scan with REFRESH_DIV = 4.
module tb_bcd_display_scan;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bcd_display_scan_if #(.NDIG(4), .WIDTH(14)) bus ();

  bcd_display_scan #(
    .NDIG        (4),
    .WIDTH       (14),
    .REFRESH_DIV (4),
    .LZ_BLANK    (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Drive a load across one rising edge, released just after it.
  task automatic start_load(input logic [13:0] v);
    @(negedge clk);
    bus.value_in = v;
    bus.load     = 1'b1;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
  endtask

  // Count falling edges with busy high after an accepted load (bounded).
  // If inject is set, pulse load with value 42 during the 5th busy cycle.
  task automatic measure_busy(input bit inject, output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      bus.load = 1'b0;
      if (!bus.busy) break;
      n++;
      if (inject && n == 5) begin
        bus.value_in = 14'd42;
        bus.load     = 1'b1;
      end
    end
  endtask

  task automatic check_busy(input string name, input int n);
    checks++;
    if (n !== 14) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected 14", name, n);
    end
  endtask

  task automatic check_ovf(input string name, input logic exp);
    checks++;
    if (bus.ovf !== exp) begin
      errors++;
      $display("FAIL %s ovf: got %b expected %b", name, bus.ovf, exp);
    end
  endtask

  // Visit each digit position and compare its code; exp = {d3,d2,d1,d0}.
  task automatic check_display(input string name, input logic [15:0] exp);
    logic [3:0] want_an;
    bit         found;
    for (int i = 0; i < 4; i++) begin
      want_an = ~(4'b0001 << i);
      found   = 1'b0;
      for (int k = 0; k < 24; k++) begin
        @(negedge clk);
        if (bus.an === want_an) begin
          found = 1'b1;
          break;
        end
      end
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL %s digit%0d: an never reached %b", name, i, want_an);
      end else if (bus.bcd !== exp[4*i +: 4]) begin
        errors++;
        $display("FAIL %s digit%0d: got %h expected %h", name, i, bus.bcd, exp[4*i +: 4]);
      end
    end
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.load     = 1'b0;
    bus.value_in = '0;
    #13;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.busy !== 1'b0 || bus.ovf !== 1'b0 || bus.an !== 4'b1110 || bus.bcd !== 4'h0) begin
        errors++;
        $display("FAIL reset: busy=%b ovf=%b an=%b bcd=%h expected 0 0 1110 0",
                 bus.busy, bus.ovf, bus.an, bus.bcd);
      end
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  task automatic test_load_1234();
    int         n;
    logic [3:0] prev;
    logic [3:0] want_an;
    logic [3:0] want_bcd;
    logic [15:0] exp;
    start_load(14'd1234);
    measure_busy(1'b0, n);
    check_busy("load_1234", n);
    check_ovf("load_1234", 1'b0);
    // Align to the first cycle of digit 0.
    prev = bus.an;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (prev === 4'b0111 && bus.an === 4'b1110) break;
      prev = bus.an;
    end
    exp = 16'h1234;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      want_an  = ~(4'b0001 << (c / 4));
      want_bcd = exp[4*(c/4) +: 4];
      checks++;
      if (bus.an !== want_an || bus.bcd !== want_bcd) begin
        errors++;
        $display("FAIL scan_1234 cycle%0d: an=%b bcd=%h expected an=%b bcd=%h",
                 c, bus.an, bus.bcd, want_an, want_bcd);
      end
    end
  endtask

  task automatic test_lz_blank();
    int n;
    start_load(14'd7);
    measure_busy(1'b0, n);
    check_busy("lz_7", n);
    check_display("lz_7", 16'hFFF7);
    start_load(14'd0);
    measure_busy(1'b0, n);
    check_busy("lz_0", n);
    check_display("lz_0", 16'hFFF0);
    start_load(14'd1000);
    measure_busy(1'b0, n);
    check_busy("lz_1000", n);
    check_display("lz_1000", 16'h1000);
  endtask

  task automatic test_overflow();
    int n;
    start_load(14'd10000);
    measure_busy(1'b0, n);
    check_busy("ovf_10000", n);
    check_ovf("ovf_10000", 1'b1);
    check_display("ovf_10000", 16'hFFFF);
    start_load(14'd9999);
    measure_busy(1'b0, n);
    check_busy("ovf_9999", n);
    check_ovf("ovf_9999", 1'b0);
    check_display("ovf_9999", 16'h9999);
  endtask

  task automatic test_load_while_busy();
    int n;
    start_load(14'd1234);
    measure_busy(1'b1, n);
    check_busy("busy_load", n);
    check_display("busy_load", 16'h1234);
  endtask

  task automatic test_reset_mid_conv();
    int n;
    start_load(14'd5678);
    repeat (7) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.an !== 4'b1110 || bus.bcd !== 4'h0 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b ovf=%b an=%b bcd=%h expected 0 0 1110 0",
               bus.busy, bus.ovf, bus.an, bus.bcd);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: busy=%b expected 0", bus.busy);
    end
    check_display("reset_mid_zero", 16'hFFF0);
    start_load(14'd5678);
    measure_busy(1'b0, n);
    check_busy("reload_5678", n);
    check_display("reload_5678", 16'h5678);
  endtask

  initial begin
    test_reset();
    test_load_1234();
    test_lz_blank();
    test_overflow();
    test_load_while_busy();
    test_reset_mid_conv();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
